// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: steps each instruction through fetch, decode, execute,
// memory and writeback over a shared ALU and memory port, with wait-state timeout and sticky fault.
module multicycle_control #(
   parameter int ALUOP_W     = 4,
   parameter int MEM_TIMEOUT = 15,
   parameter int STATE_W     = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               BranchNE,
   output logic [1:0]         PCSource,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               MemtoReg,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               fault,
   output logic [STATE_W-1:0] state
);
   localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(MEM_TIMEOUT);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_NOP   = 6'b110110;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADDR = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC_R  = 4'd6,
      S_WB_R    = 4'd7,
      S_BRANCH  = 4'd8,
      S_JUMP    = 4'd9,
      S_EXEC_I  = 4'd10,
      S_WB_I    = 4'd11,
      S_FAULT   = 4'd15
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] wait_reg, wait_next, wait_inc;
   logic             fault_reg;
   logic             mem_state, timeout_hit;
   logic [3:0]       aluop4;

   always_comb begin
      mem_state   = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
      wait_inc    = (&wait_reg) ? wait_reg : wait_reg + CNT_W'(1);
      // a ready in the limit cycle still advances normally
      timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_inc >= TIMEOUT_LIM);
      state_next  = state_reg;
      case (state_reg)
         S_FETCH:   if (mem_ready) state_next = S_DECODE;
                    else if (timeout_hit) state_next = S_FAULT;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:    state_next = S_MEMADDR;
               OP_RTYPE:        state_next = S_EXEC_R;
               OP_BEQ, OP_BNE:  state_next = S_BRANCH;
               OP_J:            state_next = S_JUMP;
               OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
               OP_XORI, OP_SLTI, OP_SLTIU: state_next = S_EXEC_I;
               OP_NOP:          state_next = S_FETCH;
               default:         state_next = S_FAULT;
            endcase
         end
         S_MEMADDR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (mem_ready) state_next = S_MEMWB;
                    else if (timeout_hit) state_next = S_FAULT;
         S_MEMWR:   if (mem_ready) state_next = S_FETCH;
                    else if (timeout_hit) state_next = S_FAULT;
         S_EXEC_R:  state_next = S_WB_R;
         S_EXEC_I:  state_next = S_WB_I;
         S_MEMWB, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: state_next = S_FETCH;
         S_FAULT:   state_next = S_FAULT;
         default:   state_next = S_FAULT;
      endcase
      wait_next = (mem_state && !mem_ready && (state_next == state_reg)) ? wait_inc : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_FETCH;
         wait_reg  <= '0;
         fault_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         wait_reg  <= wait_next;
         fault_reg <= fault_reg | (state_next == S_FAULT);
      end
   end

   // Outputs decode from the registered state so an async reset drops them at once.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchNE    = 1'b0;
      PCSource    = 2'b00;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      aluop4      = 4'b0000;
      case (state_reg)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE:  ALUSrcB = 2'b11;
         S_MEMADDR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
         S_MEMRD:   begin MemRead = 1'b1; IorD = 1'b1; end
         S_MEMWB:   begin MemtoReg = 1'b1; RegWrite = 1'b1; end
         S_MEMWR:   begin MemWrite = 1'b1; IorD = 1'b1; end
         S_EXEC_R:  begin ALUSrcA = 1'b1; aluop4 = 4'b0010; end
         S_WB_R:    begin RegDst = 1'b1; RegWrite = 1'b1; end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            BranchNE    = (opcode == OP_BNE);
            aluop4      = (opcode == OP_BNE) ? 4'b1011 : 4'b0001;
         end
         S_JUMP:    begin PCWrite = 1'b1; PCSource = 2'b10; aluop4 = 4'b1100; end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (opcode)
               OP_ADDI:  aluop4 = 4'b0100;
               OP_ADDIU: aluop4 = 4'b0101;
               OP_ANDI:  aluop4 = 4'b0110;
               OP_ORI:   aluop4 = 4'b0111;
               OP_XORI:  aluop4 = 4'b1000;
               OP_SLTI:  aluop4 = 4'b1001;
               OP_SLTIU: aluop4 = 4'b1010;
               default:  aluop4 = 4'b0000;
            endcase
         end
         S_WB_I:    RegWrite = 1'b1;
         S_FAULT:   aluop4 = 4'b1111;
         default:   aluop4 = 4'b0000;
      endcase
   end

   assign ALUOp = ALUOP_W'(aluop4);
   assign fault = fault_reg;
   assign state = STATE_W'(state_reg);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus random instruction streams,
// all checked cycle by cycle against an instruction-path model.
module tb_multicycle_control;
   localparam int TO = 4;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_NOP   = 6'b110110;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, fault;
   logic [1:0] PCSource, ALUSrcB;
   logic [3:0] ALUOp, state;

   multicycle_control #(.ALUOP_W(4), .MEM_TIMEOUT(TO), .STATE_W(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
      .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .fault(fault), .state(state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Model: current step, remaining steps of this instruction, wait cycles so far.
   int mcur = 0;
   int mq[$];
   int wcnt = 0;
   logic [5:0] cur_op;
   logic       cur_r;

   int s_state, s_aluop, s_pcw, s_pcs, s_bne, s_rw, s_m2r, s_mw, s_irw, s_fault;

   logic [5:0] legal [14];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   function automatic logic [23:0] expect_out(input int st, input logic [5:0] op, input logic r);
      logic pcw, pcc, bne, iord, mr, mw, irw, m2r, rd, rw, asa, flt;
      logic [1:0] pcs, asb;
      logic [3:0] aop;
      {pcw, pcc, bne, iord, mr, mw, irw, m2r, rd, rw, asa, flt} = '0;
      pcs = 2'b00; asb = 2'b00; aop = 4'b0000;
      case (st)
         0:  begin mr = 1; asb = 2'b01; irw = r; pcw = r; end
         1:  asb = 2'b11;
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mr = 1; iord = 1; end
         4:  begin m2r = 1; rw = 1; end
         5:  begin mw = 1; iord = 1; end
         6:  begin asa = 1; aop = 4'b0010; end
         7:  begin rd = 1; rw = 1; end
         8:  begin
                asa = 1; pcc = 1; pcs = 2'b01;
                if (op == OP_BNE) begin aop = 4'b1011; bne = 1; end
                else aop = 4'b0001;
             end
         9:  begin pcw = 1; pcs = 2'b10; aop = 4'b1100; end
         10: begin
                asa = 1; asb = 2'b10;
                case (op)
                   OP_ADDI:  aop = 4'd4;
                   OP_ADDIU: aop = 4'd5;
                   OP_ANDI:  aop = 4'd6;
                   OP_ORI:   aop = 4'd7;
                   OP_XORI:  aop = 4'd8;
                   OP_SLTI:  aop = 4'd9;
                   OP_SLTIU: aop = 4'd10;
                   default:  aop = 4'd0;
                endcase
             end
         11: rw = 1;
         15: begin aop = 4'b1111; flt = 1; end
         default: ;
      endcase
      return {pcw, pcc, bne, pcs, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, flt, 4'(st)};
   endfunction

   task automatic model_tick(input logic [5:0] op, input logic r);
      bit illegal;
      if (mcur == 15) return;
      if ((mcur == 0 || mcur == 3 || mcur == 5) && !r) begin
         if (wcnt < 1000) wcnt++;
         if (TO != 0 && wcnt >= TO) begin mcur = 15; mq.delete(); end
         return;
      end
      wcnt = 0;
      if (mcur == 0) mcur = 1;
      else if (mcur == 1) begin
         illegal = 0;
         mq.delete();
         case (op)
            OP_LW:          mq = '{2, 3, 4};
            OP_SW:          mq = '{2, 5};
            OP_R:           mq = '{6, 7};
            OP_BEQ, OP_BNE: mq = '{8};
            OP_J:           mq = '{9};
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU: mq = '{10, 11};
            OP_NOP:         ;
            default:        illegal = 1;
         endcase
         if (illegal) mcur = 15;
         else if (mq.size() == 0) mcur = 0;
         else mcur = mq.pop_front();
      end else begin
         mcur = (mq.size() > 0) ? mq.pop_front() : 0;
      end
   endtask

   task automatic drive_check(input logic [5:0] op, input logic r);
      logic [23:0] act, want;
      @(negedge clk);
      opcode = op; mem_ready = r; cur_op = op; cur_r = r;
      #1;
      act = {PCWrite, PCWriteCond, BranchNE, PCSource, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, fault, state};
      want = expect_out(mcur, op, r);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL cycle_check t=%0t model_state=%0d got=%h want=%h", $time, mcur, act, want);
      end
      s_state = int'(state); s_aluop = int'(ALUOp); s_pcw = int'(PCWrite); s_pcs = int'(PCSource);
      s_bne = int'(BranchNE); s_rw = int'(RegWrite); s_m2r = int'(MemtoReg); s_mw = int'(MemWrite);
      s_irw = int'(IRWrite); s_fault = int'(fault);
   endtask

   task automatic advance();
      @(posedge clk);
      model_tick(cur_op, cur_r);
   endtask

   task automatic step(input logic [5:0] op, input logic r);
      drive_check(op, r);
      advance();
   endtask

   // Called in the low phase after drive_check; reset is asserted away from any edge.
   task automatic do_reset_mid(input string why);
      mem_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk({why, "_rst_state"}, 32'(state), 0);
      chk({why, "_rst_fault"}, 32'(fault), 0);
      chk({why, "_rst_regwrite"}, 32'(RegWrite), 0);
      chk({why, "_rst_memwrite"}, 32'(MemWrite), 0);
      chk({why, "_rst_pcwrite"}, 32'(PCWrite), 0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      mcur = 0; wcnt = 0; mq.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before the bench finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq_want [6];
      int mw_cnt, fcnt, ninstr;
      logic [5:0] rop;
      logic r;
      legal = '{OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW, OP_NOP};
      seq_want = '{0, 1, 2, 3, 4, 0};

      // reset state with FETCH outputs and mem_ready gating
      #2;
      chk("reset_state", 32'(state), 0);
      chk("reset_fault", 32'(fault), 0);
      chk("reset_memread", 32'(MemRead), 1);
      chk("reset_irwrite_gated", 32'(IRWrite), 0);
      @(posedge clk);
      #2;
      reset = 1'b0;

      // LW with mem_ready tied high
      for (int i = 0; i < 6; i++) begin
         step(OP_LW, i < 5);
         chk($sformatf("lw_seq%0d", i), 32'(s_state), 32'(seq_want[i]));
         chk($sformatf("lw_regwrite%0d", i), 32'(s_rw), (i == 4) ? 1 : 0);
         if (i == 4) chk("lw_memtoreg", 32'(s_m2r), 1);
      end
      $display("txn LW: done");

      // RTYPE
      step(OP_R, 1); step(OP_R, 1); step(OP_R, 1);
      chk("rtype_exec_state", 32'(s_state), 6);
      chk("rtype_aluop", 32'(s_aluop), 2);
      step(OP_R, 1);
      chk("rtype_wb_regwrite", 32'(s_rw), 1);
      step(OP_R, 0);
      chk("rtype_return", 32'(s_state), 0);
      $display("txn RTYPE: done");

      // BNE
      step(OP_BNE, 1); step(OP_BNE, 1); step(OP_BNE, 1);
      chk("bne_state", 32'(s_state), 8);
      chk("bne_aluop", 32'(s_aluop), 11);
      chk("bne_branchne", 32'(s_bne), 1);
      step(OP_BNE, 0);
      chk("bne_return", 32'(s_state), 0);
      $display("txn BNE: done");

      // J
      step(OP_J, 1); step(OP_J, 1); step(OP_J, 1);
      chk("j_state", 32'(s_state), 9);
      chk("j_pcsource", 32'(s_pcs), 2);
      chk("j_pcwrite", 32'(s_pcw), 1);
      step(OP_J, 0);
      chk("j_return", 32'(s_state), 0);
      $display("txn J: done");

      // SW with three wait cycles in MEMWR
      mw_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         step(OP_SW, (i < 3 || i == 6));
         mw_cnt += s_mw;
      end
      chk("sw_memwrite_cycles", 32'(mw_cnt), 4);
      chk("sw_no_fault", 32'(s_fault), 0);
      step(OP_SW, 0);
      chk("sw_return", 32'(s_state), 0);
      $display("txn SW-wait: done");

      // NOP
      step(OP_NOP, 1); step(OP_NOP, 1);
      chk("nop_decode_state", 32'(s_state), 1);
      chk("nop_no_enables", 32'(s_rw | s_mw | s_pcw | s_irw), 0);
      step(OP_NOP, 0);
      chk("nop_return", 32'(s_state), 0);
      $display("txn NOP: done");

      // async reset while in MEMWB
      step(OP_LW, 1); step(OP_LW, 1); step(OP_LW, 1); step(OP_LW, 1);
      drive_check(OP_LW, 1);
      chk("memwb_regwrite_before", 32'(s_rw), 1);
      do_reset_mid("memwb");
      $display("txn reset-in-MEMWB: done");

      // illegal opcode
      step(6'b111111, 1); step(6'b111111, 1);
      drive_check(6'b111111, 1);
      chk("illegal_state", 32'(s_state), 15);
      chk("illegal_fault", 32'(s_fault), 1);
      chk("illegal_aluop", 32'(s_aluop), 15);
      do_reset_mid("illegal");
      $display("txn illegal: done");

      // timeout in FETCH
      for (int i = 0; i < TO; i++) begin
         step(OP_LW, 0);
         chk($sformatf("to_wait%0d", i), 32'(s_state), 0);
      end
      for (int i = 0; i < 3; i++) begin
         step(OP_LW, 1);
         chk($sformatf("to_fault_state%0d", i), 32'(s_state), 15);
         chk($sformatf("to_fault_sticky%0d", i), 32'(s_fault), 1);
      end
      drive_check(OP_LW, 1);
      do_reset_mid("timeout");
      $display("txn timeout: done");

      // ready in the limit cycle wins
      for (int i = 0; i < TO; i++) step(OP_J, (i == TO - 1));
      step(OP_J, 1);
      chk("limit_ready_decode", 32'(s_state), 1);
      step(OP_J, 1);
      chk("limit_ready_jump", 32'(s_state), 9);
      step(OP_J, 0);
      $display("txn ready-at-limit: done");

      // random stream
      rop = OP_NOP; fcnt = 0; ninstr = 0;
      for (int c = 0; c < 3000; c++) begin
         if (mcur == 0) begin
            if ($urandom_range(0, 24) == 0) rop = 6'($urandom_range(0, 63));
            else rop = legal[$urandom_range(0, 13)];
         end
         r = ($urandom_range(0, 99) < 65);
         if (mcur == 1) ninstr++;
         drive_check(rop, r);
         fcnt = (mcur == 15) ? fcnt + 1 : 0;
         if (fcnt >= 3 || $urandom_range(0, 299) == 0) begin
            do_reset_mid("random");
            fcnt = 0;
         end else begin
            advance();
         end
      end
      $display("txn random: %0d decodes", ninstr);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
